// File: rtl/spi_slave_regif.sv
// spi_slave_regif: SPI responder for CPHA=0 frames (mode 0 / mode 2 via CPOL).
// A frame is a HEADER_LEN-bit instruction header (MSB = R/W, low ADDR_WIDTH
// bits = register address) followed by either WDATA_WIDTH write bits on MOSI
// or RDATA_WIDTH read bits returned on MISO.
//
// Register interface protocol: reg_wr_en and reg_rd_en are single-cycle
// strobes with no back-pressure. reg_addr (and reg_wr_data for writes) are
// valid in the strobe cycle. For reads, the register block must present
// reg_rd_data in the cycle immediately after reg_rd_en; it is captured then.
//
// Optional feature: define SPI_SLAVE_ERR_CNT_EN to add err_cnt[15:0], a
// saturating count of frame_err pulses that only nrst clears.
module spi_slave_regif #(
   parameter int CPOL        = 0,
   parameter int HEADER_LEN  = 16,
   parameter int ADDR_WIDTH  = 8,
   parameter int WDATA_WIDTH = 8,
   parameter int RDATA_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   sclk_pin,
   input  logic                   ncs_pin,
   input  logic                   mosi_pin,
   output logic                   miso_pin,
   output logic                   miso_oe,
   output logic [ADDR_WIDTH-1:0]  reg_addr,
   output logic                   reg_wr_en,
   output logic [WDATA_WIDTH-1:0] reg_wr_data,
   output logic                   reg_rd_en,
   input  logic [RDATA_WIDTH-1:0] reg_rd_data,
   output logic                   frame_active,
   output logic                   frame_err
`ifdef SPI_SLAVE_ERR_CNT_EN
   ,
   output logic [15:0]            err_cnt
`endif
);

   // Longest bit run the counter must cover inside one frame phase.
   localparam int MAX_HW   = (HEADER_LEN > WDATA_WIDTH) ? HEADER_LEN : WDATA_WIDTH;
   localparam int MAX_BITS = (MAX_HW > RDATA_WIDTH) ? MAX_HW : RDATA_WIDTH;
   localparam int CNT_W    = $clog2(MAX_BITS + 1);
   // Receive shifter keeps all but the bit arriving this cycle.
   localparam int RX_W     = MAX_BITS - 1;

   localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HEADER_LEN - 1);
   localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WDATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RDATA_WIDTH - 1);
   localparam logic             CPOL_LVL = (CPOL != 0);

   // ST_RD_REQ: reg_rd_en is high; ST_RD_CAP: reg_rd_data is valid and captured.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_WDATA,
      ST_RD_REQ,
      ST_RD_CAP,
      ST_RDATA,
      ST_DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [2:0]             sclk_sync;
   logic [2:0]             ncs_sync;
   logic [1:0]             mosi_sync;
   logic                   sclk_rise;
   logic                   sclk_fall;
   logic                   sample_edge;
   logic                   shift_edge;
   logic                   ncs_fall;
   logic                   ncs_rise;
   logic                   mosi_bit;

   logic [CNT_W-1:0]       bit_cnt;
   logic [RX_W-1:0]        rx_sr;
   logic [RDATA_WIDTH-1:0] tx_sr;
   logic                   overrun;
   logic                   counting;

   logic                   hdr_done;
   logic                   wr_done;
   logic                   frame_bad;
   logic                   hdr_rw;
   logic [ADDR_WIDTH-1:0]  hdr_addr;
   logic [WDATA_WIDTH-1:0] wr_word;

   // Synchronise the pins; the third SCLK/NCS flop is the edge-detect reference.
   // The NCS chain resets to "selected" so that a frame already in progress
   // when reset is released produces no falling edge and is ignored.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sclk_sync <= {3{CPOL_LVL}};
         ncs_sync  <= 3'b000;
         mosi_sync <= 2'b00;
      end else begin
         sclk_sync <= {sclk_sync[1:0], sclk_pin};
         ncs_sync  <= {ncs_sync[1:0], ncs_pin};
         mosi_sync <= {mosi_sync[0], mosi_pin};
      end
   end

   assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
   assign sample_edge = CPOL_LVL ? sclk_fall : sclk_rise;
   assign shift_edge  = CPOL_LVL ? sclk_rise : sclk_fall;
   assign ncs_fall    = ~ncs_sync[1] & ncs_sync[2];
   assign ncs_rise    = ncs_sync[1] & ~ncs_sync[2];
   assign mosi_bit    = mosi_sync[1];

   // Header fields as they will look once the bit arriving now is shifted in.
   assign hdr_rw   = rx_sr[HEADER_LEN-2];
   assign hdr_addr = {rx_sr[ADDR_WIDTH-2:0], mosi_bit};
   assign wr_word  = {rx_sr[WDATA_WIDTH-2:0], mosi_bit};
   assign counting = (state_q == ST_HEADER) || (state_q == ST_WDATA) ||
                     (state_q == ST_RDATA);

   // FSM state register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode plus the single-cycle events derived from it.
   always_comb begin
      state_d   = state_q;
      hdr_done  = 1'b0;
      wr_done   = 1'b0;
      frame_bad = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // An SCLK edge coincident with the NCS fall is not counted.
            if (ncs_fall) state_d = ST_HEADER;
         end
         ST_HEADER: begin
            if (sample_edge && (bit_cnt == HDR_LAST)) begin
               hdr_done = 1'b1;
               state_d  = hdr_rw ? ST_RD_REQ : ST_WDATA;
            end
         end
         ST_WDATA: begin
            if (sample_edge && (bit_cnt == WR_LAST)) begin
               wr_done = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_RD_REQ: state_d = ST_RD_CAP;
         ST_RD_CAP: state_d = ST_RDATA;
         ST_RDATA: begin
            if (sample_edge && (bit_cnt == RD_LAST)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
      // Deselect always wins: it aborts the frame and suppresses a pending write.
      if (ncs_rise && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         hdr_done  = 1'b0;
         wr_done   = 1'b0;
         frame_bad = (state_q == ST_DONE) ? (overrun | sample_edge) : 1'b1;
      end
   end

   // Bit counter: restarts on every state change, counts sample edges per phase.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                        bit_cnt <= '0;
      else if (state_d != state_q)      bit_cnt <= '0;
      else if (sample_edge && counting) bit_cnt <= bit_cnt + CNT_W'(1);
   end

   // Receive shifter for header and write payload.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_sr <= '0;
      end else if (state_q == ST_IDLE) begin
         rx_sr <= '0;
      end else if (sample_edge && ((state_q == ST_HEADER) || (state_q == ST_WDATA))) begin
         rx_sr <= {rx_sr[RX_W-2:0], mosi_bit};
      end
   end

   // Remember sample edges seen after the frame completed (over-long frame).
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                    overrun <= 1'b0;
      else if (state_q != ST_DONE)  overrun <= 1'b0;
      else if (sample_edge)         overrun <= 1'b1;
   end

   // Register-interface strobes and their address/data.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         reg_addr    <= '0;
         reg_wr_en   <= 1'b0;
         reg_wr_data <= '0;
         reg_rd_en   <= 1'b0;
      end else begin
         reg_wr_en <= wr_done;
         reg_rd_en <= hdr_done & hdr_rw;
         if (hdr_done) reg_addr    <= hdr_addr;
         if (wr_done)  reg_wr_data <= wr_word;
      end
   end

   // Transmit path: capture read data, then present one bit per shift edge.
   // A shift edge landing in the capture cycle (SCLK near the 4x limit) is
   // served straight from reg_rd_data so the MSB is never lost.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tx_sr    <= '0;
         miso_pin <= 1'b0;
      end else begin
         if (state_q == ST_RD_CAP) begin
            if (shift_edge) begin
               miso_pin <= reg_rd_data[RDATA_WIDTH-1];
               tx_sr    <= reg_rd_data << 1;
            end else begin
               tx_sr <= reg_rd_data;
            end
         end else if ((state_q == ST_RDATA) && shift_edge) begin
            miso_pin <= tx_sr[RDATA_WIDTH-1];
            tx_sr    <= tx_sr << 1;
         end
         if (state_d != ST_RDATA) miso_pin <= 1'b0;
      end
   end

   // Frame status and MISO enable, registered for clean pin-level outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         frame_active <= 1'b0;
         frame_err    <= 1'b0;
         miso_oe      <= 1'b0;
      end else begin
         frame_active <= (state_d != ST_IDLE);
         frame_err    <= frame_bad;
         miso_oe      <= (state_d == ST_RDATA);
      end
   end

`ifdef SPI_SLAVE_ERR_CNT_EN
   // Saturating count of malformed frames; only nrst clears it.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                               err_cnt <= '0;
      else if (frame_bad && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: one CPOL=0 instance and one CPOL=1
// instance, an SPI master task, and a one-cycle-latency register model.
module tb_spi_slave_regif;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   // CPOL = 0 instance signals
   logic       sclk0, ncs0, mosi0;
   logic       miso0, oe0, wr0, rd0, fa0, ferr0;
   logic [7:0] addr0, wdata0;
   logic [7:0] rdata0 = 8'h00;
   // CPOL = 1 instance signals
   logic       sclk1, ncs1, mosi1;
   logic       miso1, oe1, wr1, rd1, fa1, ferr1;
   logic [7:0] addr1, wdata1;
   logic [7:0] rdata1 = 8'h00;
`ifdef SPI_SLAVE_ERR_CNT_EN
   logic [15:0] ecnt0, ecnt1;
`endif

   int checks = 0;
   int errors = 0;

   int         wr_n0, rd_n0, err_n0, wr_n1, rd_n1, err_n1;
   logic [7:0] wr_addr0, wr_data0, rd_addr0, rd_addr1;
   logic [7:0] rd_val0, rd_val1;

   spi_slave_regif #(.CPOL(0)) dut0 (
      .clk          (clk),
      .nrst         (nrst),
      .sclk_pin     (sclk0),
      .ncs_pin      (ncs0),
      .mosi_pin     (mosi0),
      .miso_pin     (miso0),
      .miso_oe      (oe0),
      .reg_addr     (addr0),
      .reg_wr_en    (wr0),
      .reg_wr_data  (wdata0),
      .reg_rd_en    (rd0),
      .reg_rd_data  (rdata0),
      .frame_active (fa0),
      .frame_err    (ferr0)
`ifdef SPI_SLAVE_ERR_CNT_EN
      ,
      .err_cnt      (ecnt0)
`endif
   );

   spi_slave_regif #(.CPOL(1)) dut1 (
      .clk          (clk),
      .nrst         (nrst),
      .sclk_pin     (sclk1),
      .ncs_pin      (ncs1),
      .mosi_pin     (mosi1),
      .miso_pin     (miso1),
      .miso_oe      (oe1),
      .reg_addr     (addr1),
      .reg_wr_en    (wr1),
      .reg_wr_data  (wdata1),
      .reg_rd_en    (rd1),
      .reg_rd_data  (rdata1),
      .frame_active (fa1),
      .frame_err    (ferr1)
`ifdef SPI_SLAVE_ERR_CNT_EN
      ,
      .err_cnt      (ecnt1)
`endif
   );

   // Register block model: read data valid the cycle after reg_rd_en, zero otherwise.
   always @(posedge clk) begin
      rdata0 <= rd0 ? rd_val0 : 8'h00;
      rdata1 <= rd1 ? rd_val1 : 8'h00;
   end

   // Strobe monitor, sampled on the falling clock edge.
   always @(negedge clk) begin
      if (wr0) begin wr_n0++; wr_addr0 = addr0; wr_data0 = wdata0; end
      if (rd0) begin rd_n0++; rd_addr0 = addr0; end
      if (ferr0) err_n0++;
      if (wr1) wr_n1++;
      if (rd1) begin rd_n1++; rd_addr1 = addr1; end
      if (ferr1) err_n1++;
   end

   task automatic clear_counts();
      wr_n0 = 0; rd_n0 = 0; err_n0 = 0;
      wr_n1 = 0; rd_n1 = 0; err_n1 = 0;
   endtask

   task automatic half_period();
      repeat (4) @(negedge clk);
   endtask

   // One CPHA=0 frame of nclks SCLK cycles; data bits go out MSB first from data[23].
   // rx collects MISO at sample edges 16..23; oe_vec[23-i] is miso_oe at sample edge i.
   task automatic spi_frame(input bit use1, input logic [23:0] data, input int nclks,
                            output logic [7:0] rx, output logic [23:0] oe_vec,
                            output int err_pre, output logic fa_mid);
      logic idle_lvl;
      idle_lvl = use1;
      rx       = 8'h00;
      oe_vec   = 24'h0;
      fa_mid   = 1'b0;
      if (use1) begin ncs1 = 1'b0; mosi1 = data[23]; end
      else      begin ncs0 = 1'b0; mosi0 = data[23]; end
      half_period();
      for (int i = 0; i < nclks; i++) begin
         if (i >= 16 && i < 24) rx = {rx[6:0], (use1 ? miso1 : miso0)};
         if (i < 24) oe_vec[23-i] = use1 ? oe1 : oe0;
         if (i == 8) fa_mid = use1 ? fa1 : fa0;
         if (use1) sclk1 = ~idle_lvl; else sclk0 = ~idle_lvl;
         half_period();
         if (use1) begin sclk1 = idle_lvl; mosi1 = (i < 23) ? data[22-i] : 1'b0; end
         else      begin sclk0 = idle_lvl; mosi0 = (i < 23) ? data[22-i] : 1'b0; end
         half_period();
      end
      half_period();
      err_pre = use1 ? err_n1 : err_n0;
      if (use1) ncs1 = 1'b1; else ncs0 = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({miso0, oe0, wr0, rd0, fa0, ferr0, addr0, wdata0} !== 22'h0) begin
         errors++;
         $display("FAIL reset_outputs0 got=%h want=0", {miso0, oe0, wr0, rd0, fa0, ferr0, addr0, wdata0});
      end
      checks++;
      if ({miso1, oe1, wr1, rd1, fa1, ferr1, addr1, wdata1} !== 22'h0) begin
         errors++;
         $display("FAIL reset_outputs1 got=%h want=0", {miso1, oe1, wr1, rd1, fa1, ferr1, addr1, wdata1});
      end
      nrst = 1'b1;
      clear_counts();
      repeat (10) @(negedge clk);
      checks++;
      if ({fa0, fa1, wr_n0 + rd_n0 + err_n0 + wr_n1 + rd_n1 + err_n1} !== 34'h0) begin
         errors++;
         $display("FAIL idle_after_reset fa0=%b fa1=%b events=%0d want 0",
                  fa0, fa1, wr_n0 + rd_n0 + err_n0 + wr_n1 + rd_n1 + err_n1);
      end
   endtask

   task automatic test_write();
      logic [7:0] rx; logic [23:0] oev; int ep; logic fm;
      clear_counts();
      spi_frame(1'b0, 24'h5aa5cf, 24, rx, oev, ep, fm);
      checks++;
      if (wr_n0 !== 1) begin errors++; $display("FAIL write_count got=%0d want=1", wr_n0); end
      checks++;
      if (wr_addr0 !== 8'ha5) begin errors++; $display("FAIL write_addr got=%h want=a5", wr_addr0); end
      checks++;
      if (wr_data0 !== 8'hcf) begin errors++; $display("FAIL write_data got=%h want=cf", wr_data0); end
      checks++;
      if (err_n0 !== 0 || rd_n0 !== 0) begin
         errors++; $display("FAIL write_no_err_rd err=%0d rd=%0d want 0 0", err_n0, rd_n0);
      end
      checks++;
      if (fm !== 1'b1) begin errors++; $display("FAIL write_active_mid got=%b want=1", fm); end
      checks++;
      if (fa0 !== 1'b0) begin errors++; $display("FAIL write_active_end got=%b want=0", fa0); end
      checks++;
      if (oev !== 24'h0) begin errors++; $display("FAIL write_miso_oe got=%h want=000000", oev); end
   endtask

   task automatic test_read();
      logic [7:0] rx; logic [23:0] oev; int ep; logic fm;
      clear_counts();
      rd_val0 = 8'h3c;
      spi_frame(1'b0, 24'h80a500, 24, rx, oev, ep, fm);
      checks++;
      if (rd_n0 !== 1) begin errors++; $display("FAIL read_count got=%0d want=1", rd_n0); end
      checks++;
      if (rd_addr0 !== 8'ha5) begin errors++; $display("FAIL read_addr got=%h want=a5", rd_addr0); end
      checks++;
      if (rx !== 8'h3c) begin errors++; $display("FAIL read_miso_bits got=%b want=00111100", rx); end
      checks++;
      if (oev !== 24'h0000ff) begin errors++; $display("FAIL read_miso_oe got=%h want=0000ff", oev); end
      checks++;
      if (oe0 !== 1'b0 || miso0 !== 1'b0) begin
         errors++; $display("FAIL read_pins_end oe=%b miso=%b want 0 0", oe0, miso0);
      end
      checks++;
      if (wr_n0 !== 0 || err_n0 !== 0) begin
         errors++; $display("FAIL read_no_wr_err wr=%0d err=%0d want 0 0", wr_n0, err_n0);
      end
   endtask

   task automatic test_short_frame();
      logic [7:0] rx; logic [23:0] oev; int ep; logic fm;
      clear_counts();
      spi_frame(1'b0, 24'h5aa5cf, 20, rx, oev, ep, fm);
      checks++;
      if (wr_n0 !== 0) begin errors++; $display("FAIL short_no_write got=%0d want=0", wr_n0); end
      checks++;
      if (err_n0 !== 1) begin errors++; $display("FAIL short_err_count got=%0d want=1", err_n0); end
      checks++;
      if (fa0 !== 1'b0) begin errors++; $display("FAIL short_active_end got=%b want=0", fa0); end
      clear_counts();
      spi_frame(1'b0, 24'h001077, 24, rx, oev, ep, fm);
      checks++;
      if (wr_n0 !== 1 || wr_addr0 !== 8'h10 || wr_data0 !== 8'h77) begin
         errors++;
         $display("FAIL short_recovery_write n=%0d addr=%h data=%h want 1 10 77", wr_n0, wr_addr0, wr_data0);
      end
      checks++;
      if (err_n0 !== 0) begin errors++; $display("FAIL short_recovery_err got=%0d want=0", err_n0); end
   endtask

   task automatic test_overlong();
      logic [7:0] rx; logic [23:0] oev; int ep; logic fm;
      clear_counts();
      spi_frame(1'b0, 24'h004d5e, 28, rx, oev, ep, fm);
      checks++;
      if (wr_n0 !== 1 || wr_addr0 !== 8'h4d || wr_data0 !== 8'h5e) begin
         errors++;
         $display("FAIL overlong_write n=%0d addr=%h data=%h want 1 4d 5e", wr_n0, wr_addr0, wr_data0);
      end
      checks++;
      if (ep !== 0) begin errors++; $display("FAIL overlong_err_before_ncs got=%0d want=0", ep); end
      checks++;
      if (err_n0 !== 1) begin errors++; $display("FAIL overlong_err_count got=%0d want=1", err_n0); end
   endtask

   task automatic test_cpol1();
      logic [7:0] rx; logic [23:0] oev; int ep; logic fm;
      clear_counts();
      rd_val1 = 8'ha5;
      spi_frame(1'b1, 24'h800100, 24, rx, oev, ep, fm);
      checks++;
      if (rd_n1 !== 1 || rd_addr1 !== 8'h01) begin
         errors++; $display("FAIL cpol1_read_req n=%0d addr=%h want 1 01", rd_n1, rd_addr1);
      end
      checks++;
      if (rx !== 8'ha5) begin errors++; $display("FAIL cpol1_miso_bits got=%b want=10100101", rx); end
      checks++;
      if (oev !== 24'h0000ff) begin errors++; $display("FAIL cpol1_miso_oe got=%h want=0000ff", oev); end
      checks++;
      if (err_n1 !== 0 || wr_n1 !== 0) begin
         errors++; $display("FAIL cpol1_no_err_wr err=%0d wr=%0d want 0 0", err_n1, wr_n1);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rx; logic [23:0] oev; int ep; logic fm;
      clear_counts();
      fork
         spi_frame(1'b0, 24'h0033cc, 24, rx, oev, ep, fm);
         begin
            repeat (50) @(negedge clk);
            nrst = 1'b0;
            repeat (3) @(negedge clk);
            checks++;
            if (fa0 !== 1'b0 || oe0 !== 1'b0) begin
               errors++; $display("FAIL reset_mid_outputs fa=%b oe=%b want 0 0", fa0, oe0);
            end
            repeat (30) @(negedge clk);
            nrst = 1'b1;
         end
      join
      checks++;
      if (wr_n0 !== 0 || rd_n0 !== 0) begin
         errors++; $display("FAIL reset_mid_no_strobes wr=%0d rd=%0d want 0 0", wr_n0, rd_n0);
      end
      clear_counts();
      spi_frame(1'b0, 24'h0012ab, 24, rx, oev, ep, fm);
      checks++;
      if (wr_n0 !== 1 || wr_addr0 !== 8'h12 || wr_data0 !== 8'hab) begin
         errors++;
         $display("FAIL reset_mid_fresh_write n=%0d addr=%h data=%h want 1 12 ab", wr_n0, wr_addr0, wr_data0);
      end
`ifdef SPI_SLAVE_ERR_CNT_EN
      for (int k = 0; k < 3; k++) spi_frame(1'b0, 24'h5aa5cf, 20, rx, oev, ep, fm);
      checks++;
      if (ecnt0 !== 16'd3) begin errors++; $display("FAIL err_cnt got=%0d want=3", ecnt0); end
`endif
   endtask

   initial begin
      nrst  = 1'b0;
      sclk0 = 1'b0; ncs0 = 1'b1; mosi0 = 1'b0;
      sclk1 = 1'b1; ncs1 = 1'b1; mosi1 = 1'b0;
      rd_val0 = 8'h00; rd_val1 = 8'h00;
      clear_counts();
      test_reset();
      test_write();
      test_read();
      test_short_frame();
      test_overlong();
      test_cpol1();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave_regif.md
Name: spi_slave_regif

Overview:
- SPI responder (slave) that terminates the frames issued by the team's spi_master and bridges them to a simple on-chip register interface.
- Supports CPHA=0 modes only (mode 0 when CPOL=0, mode 2 when CPOL=1).
- Oversamples SCLK, NCS and MOSI in the system clock domain. Decodes a 16-bit instruction header, then either captures write data or serves read data on MISO.
- Sits at the FPGA pin boundary, one instance per external SPI port.

Parameters:
- CPOL, 0, idle SCLK level; the sample edge is rising when 0, falling when 1.
- HEADER_LEN, 16, instruction header bits, MSB first; header[HEADER_LEN-1] is R/W (1 = read).
- ADDR_WIDTH, 8, register address = header[ADDR_WIDTH-1:0]; the remaining header bits are ignored.
- WDATA_WIDTH, 8, write payload bits following the header, MSB first.
- RDATA_WIDTH, 8, read payload bits returned on MISO, MSB first.

Ports:
- clk  in  1  system clock; must be ≥ 4× SCLK.
- nrst  in  1  asynchronous active-low reset.
- sclk_pin  in  1  SPI clock from master.
- ncs_pin  in  1  chip select, active low.
- mosi_pin  in  1  master-out data.
- miso_pin  out  1  slave-out data.
- miso_oe  out  1  MISO tristate enable, 1 = drive.
- reg_addr  out  ADDR_WIDTH  register address, valid with reg_wr_en or reg_rd_en.
- reg_wr_en  out  1  one-clk write strobe.
- reg_wr_data  out  WDATA_WIDTH  write data, valid with reg_wr_en.
- reg_rd_en  out  1  one-clk read request.
- reg_rd_data  in  RDATA_WIDTH  read data, sampled exactly 1 clk after reg_rd_en.
- frame_active  out  1  high from NCS-fall detect to NCS-rise detect.
- frame_err  out  1  one-clk pulse on a malformed frame.

Behaviour:
- Reset values: all outputs 0 except miso_pin = 0 and miso_oe = 0; FSM in IDLE; shift registers and bit counter cleared.
- Input synchronisation:
  - sclk_pin, ncs_pin and mosi_pin each pass through a 2-flop synchroniser.
  - A third flop on SCLK and NCS provides edge detection.
  - Sample edge = rising synchronised SCLK XOR CPOL; shift edge = the opposite edge.
- FSM states and transitions:
  - IDLE: NCS fall → HEADER; clear bit counter; set frame_active.
  - HEADER: shift MOSI in on each sample edge. On the HEADER_LEN-th sample, latch the address:
    - R/W = 0 → WDATA.
    - R/W = 1 → assert reg_rd_en for 1 clk; on the next clk load reg_rd_data into the TX shift register; go to RDATA.
  - WDATA: shift in WDATA_WIDTH bits. On the last sample edge, pulse reg_wr_en with reg_addr and reg_wr_data (latency ≤ 2 clk after the edge is detected); go to DONE.
  - RDATA:
    - miso_oe = 1 for the whole state.
    - TX MSB goes on miso_pin at the first shift edge after the header.
    - Shift left on each subsequent shift edge.
    - After RDATA_WIDTH sample edges → DONE.
  - DONE: ignore SCLK; miso_pin = 0. NCS rise → IDLE.
- NCS rise in any state: return to IDLE within 3 clk; frame_active = 0; miso_oe = 0.
- NCS rise in HEADER, WDATA or RDATA (short frame):
  - Pulse frame_err.
  - Suppress reg_wr_en.
  - A reg_rd_en already issued is not retracted.
- Sample edges in DONE (over-long frame): bits are discarded; frame_err pulses once at NCS rise.
- NCS fall coincident with an SCLK edge: the edge is ignored; bit counting starts at the next sample edge.
- Async reset mid-frame: everything returns to reset values immediately; the frame is lost and no strobes are issued.
- The bit counter is sized for max(HEADER_LEN, WDATA_WIDTH, RDATA_WIDTH) and never wraps within a frame.

Optional Feature:
- Macro SPI_SLAVE_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt [15:0], a saturating counter incremented on each frame_err pulse.
  - It holds at 16'hFFFF and is cleared only by nrst.
- Undefined: no port, no counter logic; all other behaviour is identical.

Test Plan:
- Write frame 24'h5aa5cf, mode 0, clk/SCLK = 8 → one reg_wr_en pulse with reg_addr = 8'ha5, reg_wr_data = 8'hcf; no frame_err; frame_active low after NCS rise.
- Read frame with header 16'h80a5, reg_rd_data = 8'h3c → reg_rd_en pulse with reg_addr = 8'ha5; master samples MISO 0,0,1,1,1,1,0,0 on the 8 rising edges after the header; miso_oe high only during RDATA.
- Write frame aborted after 20 SCLKs (NCS rise) → no reg_wr_en; one frame_err pulse; FSM back in IDLE; a following valid write to 8'h10 with data 8'h77 succeeds.
- Write frame followed by 4 extra SCLKs before NCS rise → reg_wr_en fires once with the correct data; frame_err pulses once at NCS rise.
- CPOL = 1 build, read header 16'h8001, reg_rd_data = 8'ha5 → MISO returns 1,0,1,0,0,1,0,1 sampled on falling SCLK edges.
- nrst asserted mid-header, then a fresh write of 24'h0012ab → no strobes during or after the aborted frame; the fresh frame writes 8'hab to 8'h12. With SPI_SLAVE_ERR_CNT_EN, three aborted frames give err_cnt = 3.
